hpdl_text_buffer: RTL and testbench

Line-editing text buffer between the UART receiver and the HPDL-1414 scan/write logic. It takes received bytes, applies terminal-style editing (cursor, backspace, carriage return, clear), and folds lowercase to the display's uppercase set. It shifts the line left when text runs past the last place, and holds 16 display characters. A registered read port feeds the 16-place display scanner.

---
 rtl/hpdl_text_buffer.sv | 106 ++++++++++
 tb/tb_hpdl_text_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hpdl_text_buffer.sv
// Line-editing 16x7 text buffer for an HPDL-1414 display: edits land one edge after rx_valid, rd_data one edge after rd_addr.
// No backpressure: bytes arriving during the 16-cycle clear are dropped and flagged on sticky overrun.
module hpdl_text_buffer #(
   parameter logic [6:0] BLANK    = 7'h20,
   parameter logic [7:0] CLR_CHAR = 8'h1B
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic [3:0] rd_addr,
   output logic [6:0] rd_data,
   output logic [3:0] cursor,
   output logic       busy,
   output logic       scroll_evt,
   output logic       overrun
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [6:0] r_mem [16];
   logic       r_at_end;
   logic [3:0] r_k;

   logic       w_is_print;
   logic       w_is_bs;
   logic       w_is_cr;
   logic       w_is_clr;
   logic [6:0] w_ch;

   assign w_is_print = !rx_data[7] && (rx_data[6:5] != 2'b00) && (rx_data[6:0] != 7'h7F);
   assign w_is_bs    = (rx_data == 8'h08);
   assign w_is_cr    = (rx_data == 8'h0D);
   assign w_is_clr   = (rx_data == CLR_CHAR) || (rx_data == 8'h0C);
   // 0x60-0x7E fold down onto the display's 0x40-0x5E range
   assign w_ch       = (rx_data[6:5] == 2'b11) ? (rx_data[6:0] - 7'h20) : rx_data[6:0];

   assign busy = (r_state == ST_CLEAR);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (rx_valid && w_is_clr) w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (r_k == 4'd15)         w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 16; i++) r_mem[i] <= BLANK;
         rd_data    <= BLANK;
         cursor     <= 4'd0;
         r_at_end   <= 1'b0;
         r_k        <= 4'd0;
         scroll_evt <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rd_data    <= r_mem[rd_addr];
         scroll_evt <= 1'b0;
         if (r_state == ST_CLEAR) begin
            r_mem[r_k] <= BLANK;
            r_k        <= r_k + 4'd1;
            if (rx_valid) overrun <= 1'b1;
         end else if (rx_valid) begin
            if (w_is_print) begin
               if (cursor != 4'd15) begin
                  r_mem[cursor] <= w_ch;
                  cursor        <= cursor + 4'd1;
               end else if (!r_at_end) begin
                  r_mem[15] <= w_ch;
                  r_at_end  <= 1'b1;
               end else begin
                  for (int i = 0; i < 15; i++) r_mem[i] <= r_mem[i+1];
                  r_mem[15]  <= w_ch;
                  scroll_evt <= 1'b1;
               end
            end else if (w_is_bs) begin
               // with at_end set the cursor stays parked on the last place
               if (r_at_end) begin
                  r_mem[15] <= BLANK;
                  r_at_end  <= 1'b0;
               end else if (cursor != 4'd0) begin
                  r_mem[cursor - 4'd1] <= BLANK;
                  cursor               <= cursor - 4'd1;
               end
            end else if (w_is_cr) begin
               cursor   <= 4'd0;
               r_at_end <= 1'b0;
            end else if (w_is_clr) begin
               cursor   <= 4'd0;
               r_at_end <= 1'b0;
               r_k      <= 4'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hpdl_text_buffer.sv
// Bench for hpdl_text_buffer: line-level model checked every cycle, plus literal place/cursor checks.
module tb_hpdl_text_buffer;

   logic       CLK;
   logic       RST_N;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] rd_addr;
   logic [6:0] rd_data;
   logic [3:0] cursor;
   logic       busy;
   logic       scroll_evt;
   logic       overrun;

   hpdl_text_buffer dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .cursor     (cursor),
      .busy       (busy),
      .scroll_evt (scroll_evt),
      .overrun    (overrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the line as an array of characters, a cursor, and a remaining-clear count
   int  m_mem [16];
   int  m_cur, m_clr, m_rd;
   bit  m_at_end, m_scroll, m_ovr;
   bit  model_valid = 0;

   task automatic model_byte(input int b);
      int ch;
      if (b >= 8'h20 && b <= 8'h7E) begin
         ch = (b >= 8'h60) ? b - 8'h20 : b;
         if (m_cur < 15) begin
            m_mem[m_cur] = ch;
            m_cur++;
         end else if (!m_at_end) begin
            m_mem[15] = ch;
            m_at_end  = 1;
         end else begin
            for (int i = 0; i < 15; i++) m_mem[i] = m_mem[i+1];
            m_mem[15] = ch;
            m_scroll  = 1;
         end
      end else if (b == 8'h08) begin
         if (m_at_end) begin
            m_mem[15] = 8'h20;
            m_at_end  = 0;
         end else if (m_cur > 0) begin
            m_cur--;
            m_mem[m_cur] = 8'h20;
         end
      end else if (b == 8'h0D) begin
         m_cur = 0;
         m_at_end = 0;
      end else if (b == 8'h1B || b == 8'h0C) begin
         m_cur = 0;
         m_at_end = 0;
         m_clr = 16;
      end
   endtask

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 16; i++) m_mem[i] = 8'h20;
         m_cur = 0; m_at_end = 0; m_clr = 0; m_scroll = 0; m_ovr = 0; m_rd = 8'h20;
         model_valid = 1;
      end else begin
         m_rd = m_mem[rd_addr];
         m_scroll = 0;
         if (m_clr > 0) begin
            m_mem[16 - m_clr] = 8'h20;
            m_clr--;
            if (rx_valid) m_ovr = 1;
         end else if (rx_valid) begin
            model_byte(int'(rx_data));
         end
      end
   end

   int scroll_cnt = 0;
   int busy_cnt   = 0;

   always @(negedge CLK) begin
      if (model_valid) begin
         chk("cursor",     int'(cursor),     m_cur);
         chk("busy",       int'(busy),       int'(m_clr > 0));
         chk("scroll_evt", int'(scroll_evt), int'(m_scroll));
         chk("overrun",    int'(overrun),    int'(m_ovr));
         chk("rd_data",    int'(rd_data),    m_rd);
         if (scroll_evt) scroll_cnt++;
         if (busy) busy_cnt++;
      end
   end

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge CLK);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic peek(input int p, input int exp, input string name);
      rd_addr = p[3:0];
      @(negedge CLK);
      chk(name, int'(rd_data), exp);
   endtask

   string s_hello = "hello";
   string s_alpha = "ABCDEFGHIJKLMNOPQ";
   string s_scr   = "BCDEFGHIJKLMNOPQ";
   string s_exp5  = "HELLO";

   initial begin
      RST_N = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rd_addr = 4'd0;
      idle(3);
      RST_N = 1'b1;
      idle(1);
      chk("rst_cursor", int'(cursor), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_scroll", int'(scroll_evt), 0);
      for (int p = 0; p < 16; p++) peek(p, 8'h20, "rst_place");

      // lowercase folding
      for (int i = 0; i < s_hello.len(); i++) send(s_hello[i]);
      idle(1);
      for (int p = 0; p < 5; p++) peek(p, int'(s_exp5[p]), "hello_place");
      for (int p = 5; p < 16; p++) peek(p, 8'h20, "hello_blank");
      chk("hello_cursor", int'(cursor), 5);

      send(8'h1B);
      idle(20);

      // fill to the last place, then one more to force a scroll
      for (int i = 0; i < 16; i++) send(s_alpha[i]);
      idle(1);
      peek(15, 8'h50, "fill_place15");
      chk("fill_cursor", int'(cursor), 15);
      chk("fill_noscroll", scroll_cnt, 0);
      send(s_alpha[16]);
      idle(2);
      chk("scroll_count", scroll_cnt, 1);
      for (int p = 0; p < 16; p++) peek(p, int'(s_scr[p]), "scroll_place");

      send(8'h08);
      peek(15, 8'h20, "bs1_place15");
      chk("bs1_cursor", int'(cursor), 15);
      send(8'h08);
      peek(14, 8'h20, "bs2_place14");
      chk("bs2_cursor", int'(cursor), 14);
      peek(13, 8'h4F, "bs2_place13");
      send(8'h0D);
      chk("cr_cursor", int'(cursor), 0);
      peek(0, 8'h42, "cr_place0");
      send(8'h08);
      chk("bs0_cursor", int'(cursor), 0);
      peek(0, 8'h42, "bs0_place0");

      // clear with an overrunning byte 3 cycles after ESC
      send(8'h1B);
      idle(20);
      send("A"); send("B"); send("C"); send("D");
      busy_cnt = 0;
      send(8'h1B);
      idle(2);
      send("X");
      idle(20);
      chk("clr_busy_cycles", busy_cnt, 16);
      chk("clr_overrun", int'(overrun), 1);
      chk("clr_cursor", int'(cursor), 0);
      for (int p = 0; p < 16; p++) peek(p, 8'h20, "clr_place");

      // back-to-back bytes with an ignored BEL between
      send("A"); send(8'h07); send("B");
      idle(1);
      peek(0, 8'h41, "b2b_place0");
      peek(1, 8'h42, "b2b_place1");
      peek(2, 8'h20, "b2b_place2");
      chk("b2b_cursor", int'(cursor), 2);

      // brace folds to bracket; DEL, high-bit and FF-as-clear paths
      send("{"); send(8'h7F); send(8'hC1);
      peek(2, 8'h5B, "fold_brace");
      chk("ignore_cursor", int'(cursor), 3);
      send(8'h0C);
      idle(20);
      peek(0, 8'h20, "ff_clear_place0");
      chk("ff_clear_cursor", int'(cursor), 0);

      // asynchronous reset mid-clear
      send("Q");
      send(8'h1B);
      idle(5);
      #2 RST_N = 1'b0;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_cursor", int'(cursor), 0);
      chk("arst_overrun", int'(overrun), 0);
      chk("arst_rd_data", int'(rd_data), 8'h20);
      @(negedge CLK);
      RST_N = 1'b1;
      idle(2);
      peek(0, 8'h20, "arst_place0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
